sigma_timer: RTL



---
 rtl/sigma_timer_pkg.sv | 33 +++
 rtl/sigma_timer_prescaler.sv | 28 ++
 rtl/sigma_timer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sigma_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and byte-enable merge helper
// for the sigma_timer CSR peripheral.
package sigma_timer_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQ_EN     = 2;
  localparam int STATUS_MATCH    = 0;

  typedef struct packed {
    logic irq_en;
    logic autoreload;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sigma_timer_prescaler.sv
// Prescale counter: runs 0..prescale_i while enabled, pulsing tick_o on the
// terminal value; held at 0 when disabled and restarted on prescale rewrite.
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  restart_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || tick_o || restart_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sigma_timer.sv
// 32-bit timer/compare CSR slave on the xif bus: zero-wait-state ack, read
// data returned one cycle later, level interrupt on compare match.
module sigma_timer
  import sigma_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h80000010,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        irq_o
);

  logic        hit, wr_en, rd_en, w1c, restart, tick, cmp_hit;
  logic [2:0]  off;
  logic [31:0] rd_val, wr_val;
  logic        unused_addr;

  ctrl_t                 ctrl_q, ctrl_d;
  logic                  match_q, match_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  resp_q, resp_d;
  logic [31:0]           rdata_q, rdata_d;

  assign hit         = (bus_addr_bi[31:5] == BASE_ADDR[31:5]);
  assign off         = bus_addr_bi[4:2];
  assign unused_addr = ^bus_addr_bi[1:0];
  assign bus_ack_o   = bus_req_i & hit;
  assign wr_en       = bus_ack_o & bus_we_i;
  assign rd_en       = bus_ack_o & ~bus_we_i;
  assign restart     = wr_en && (off == OFF_PRESCALE);
  assign w1c         = wr_en && (off == OFF_STATUS) && bus_be_bi[0] && bus_wdata_bi[STATUS_MATCH];
  assign cmp_hit     = tick && (count_q == compare_q);

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (ctrl_q.en),
    .restart_i  (restart),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CTRL:     rd_val[2:0] = ctrl_q;
      OFF_STATUS:   rd_val[STATUS_MATCH] = match_q;
      OFF_COUNT:    rd_val = count_q;
      OFF_COMPARE:  rd_val = compare_q;
      OFF_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale_q;
      default:      rd_val = '0;
    endcase
  end

  // The addressed register's current value doubles as the merge base for writes.
  assign wr_val = be_merge(rd_val, bus_wdata_bi, bus_be_bi);

  always_comb begin
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    compare_d  = compare_q;
    prescale_d = prescale_q;
    match_d    = (match_q & ~w1c) | cmp_hit;
    resp_d     = rd_en;
    rdata_d    = rd_en ? rd_val : rdata_q;

    if (tick) begin
      if (cmp_hit) begin
        if (ctrl_q.autoreload) count_d = '0;
        else                   ctrl_d.en = 1'b0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    // Bus writes are applied last so they win over same-cycle timer updates.
    if (wr_en) begin
      case (off)
        OFF_CTRL:     ctrl_d     = ctrl_t'(wr_val[2:0]);
        OFF_COUNT:    count_d    = wr_val;
        OFF_COMPARE:  compare_d  = wr_val;
        OFF_PRESCALE: prescale_d = wr_val[PRESCALE_W-1:0];
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      match_q    <= 1'b0;
      count_q    <= '0;
      compare_q  <= '0;
      prescale_q <= '0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      prescale_q <= prescale_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = resp_q ? rdata_q : '0;
  assign irq_o        = match_q & ctrl_q.irq_en;

endmodule
